if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/if_stage_pc_reg.sv | 27 ++
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-state encoding, IF/ID register layout and the
// architectural reset/bubble constants used by the fetch stage.
package cpu_pkg;

  localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.instr    = nop;
    b.pc_plus4 = 32'h0000_0000;
    b.valid    = 1'b0;
    return b;
  endfunction

  function automatic ifid_t ifid_fill(input logic [31:0] instr,
                                      input logic [31:0] pc_plus4);
    ifid_t f;
    f.instr    = instr;
    f.pc_plus4 = pc_plus4;
    f.valid    = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register with load enable and synchronous active-high reset.
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  // PC update: reset value, new target on load, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem handshake,
// IF/ID pipeline register and retired-instruction counter.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc_in,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        ifid_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        fetch_stall,
  output logic [31:0] fetch_count
);

  fetch_state_e r_state;
  ifid_t        r_ifid;
  logic [31:0]  r_fetch_count;

  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus4;
  logic         w_in_fetch;
  logic         w_in_drain;
  logic         w_accept;
  logic         w_pc_load;

  assign w_in_fetch = (r_state == FS_FETCH);
  assign w_in_drain = (r_state == FS_DRAIN);
  assign w_pc_plus4 = w_pc + 32'd4;

  assign w_accept  = w_in_fetch & imem_ready & pc_write & ifid_write & ~ifid_flush;
  // A redirect is honoured in FETCH and DRAIN; BOOT has nothing in flight to squash
  assign w_pc_load = w_accept | ((w_in_fetch | w_in_drain) & ifid_flush);

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_pc_load),
    .i_d    (next_pc_in),
    .o_q    (w_pc)
  );

  // Fetch FSM together with the IF/ID register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FS_BOOT;
      r_ifid        <= ifid_bubble(NOP_INSTR);
      r_fetch_count <= 32'd0;
    end else begin
      case (r_state)
        FS_BOOT: begin
          r_state <= FS_FETCH;
        end
        FS_FETCH: begin
          if (ifid_flush) begin
            r_ifid  <= ifid_bubble(NOP_INSTR);
            r_state <= imem_ready ? FS_FETCH : FS_DRAIN;
          end else if (w_accept) begin
            r_ifid        <= ifid_fill(imem_rdata, w_pc_plus4);
            r_fetch_count <= r_fetch_count + 32'd1;
          end else if (ifid_write) begin
            r_ifid <= ifid_bubble(NOP_INSTR);
          end else begin
            r_ifid <= r_ifid;
          end
        end
        FS_DRAIN: begin
          if (ifid_write || ifid_flush) begin
            r_ifid <= ifid_bubble(NOP_INSTR);
          end else begin
            r_ifid <= r_ifid;
          end
          // The stale response retires the drain even when it coincides with a new
          // redirect; waiting for a second response would never terminate.
          if (imem_ready) begin
            r_state <= FS_FETCH;
          end else begin
            r_state <= FS_DRAIN;
          end
        end
        default: begin
          r_state <= FS_BOOT;
          r_ifid  <= ifid_bubble(NOP_INSTR);
        end
      endcase
    end
  end

  assign imem_req      = ~reset & w_in_fetch;
  assign imem_addr     = w_pc;
  assign pc_plus4_out  = w_pc_plus4;
  assign fetch_stall   = ~reset & ((w_in_fetch & ~imem_ready) | w_in_drain);
  assign ifid_instr    = r_ifid.instr;
  assign ifid_pc_plus4 = r_ifid.pc_plus4;
  assign ifid_valid    = r_ifid.valid;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: sequential fetch, stalls, hazards,
// flush/drain, reset in DRAIN, PC wrap and counter wrap.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc_in;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_plus4_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        fetch_stall;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .next_pc_in    (next_pc_in),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pc_plus4_out  (pc_plus4_out),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .fetch_stall   (fetch_stall),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rdata, input logic [31:0] npc,
                       input logic pw, input logic iw, input logic fl);
    imem_ready = rdy;
    imem_rdata = rdata;
    next_pc_in = npc;
    pc_write   = pw;
    ifid_write = iw;
    ifid_flush = fl;
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                          input logic v);
    chk({tag, "_instr"}, ifid_instr, ins);
    chk({tag, "_pc4"}, ifid_pc_plus4, p4);
    chk({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset with flush and ready asserted: reset must dominate
    reset = 1'b1;
    drive(1'b1, 32'hAAAA_0000, 32'h0000_0100, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_cnt", fetch_count, 32'd0);
    chk_ifid("rst", 32'h0000_0000, 32'h0000_0000, 1'b0);

    // BOOT cycle: no request, ready ignored
    reset = 1'b0;
    drive(1'b1, 32'hDEAD_0000, 32'h0000_0004, 1'b1, 1'b1, 1'b0);
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    chk("boot_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    chk("boot_cnt", fetch_count, 32'd0);
    chk("boot_valid", {31'd0, ifid_valid}, 32'd0);

    // sequential fetch 0x0, 0x4, 0x8
    drive(1'b1, 32'h1111_0000, 32'h0000_0004, 1'b1, 1'b1, 1'b0);
    chk("f0_req", {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h0000_0000);
    chk("f0_p4", pc_plus4_out, 32'h0000_0004);
    chk("f0_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    chk_ifid("f0", 32'h1111_0000, 32'h0000_0004, 1'b1);
    chk("f1_addr", imem_addr, 32'h0000_0004);
    drive(1'b1, 32'h1111_0001, 32'h0000_0008, 1'b1, 1'b1, 1'b0);
    tick();
    chk_ifid("f1", 32'h1111_0001, 32'h0000_0008, 1'b1);
    chk("f2_addr", imem_addr, 32'h0000_0008);
    drive(1'b1, 32'h1111_0002, 32'h0000_000C, 1'b1, 1'b1, 1'b0);
    tick();
    chk_ifid("f2", 32'h1111_0002, 32'h0000_000C, 1'b1);
    chk("f2_cnt", fetch_count, 32'd3);
    chk("f3_addr", imem_addr, 32'h0000_000C);
    drive(1'b1, 32'h1111_0003, 32'h0000_0010, 1'b1, 1'b1, 1'b0);
    tick();
    chk("f3_cnt", fetch_count, 32'd4);

    // memory wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hBAD0_0000, 32'h0000_0014, 1'b1, 1'b1, 1'b0);
      chk("ws_stall", {31'd0, fetch_stall}, 32'd1);
      chk("ws_req", {31'd0, imem_req}, 32'd1);
      tick();
      chk("ws_addr", imem_addr, 32'h0000_0010);
      chk_ifid("ws", 32'h0000_0000, 32'h0000_0000, 1'b0);
      chk("ws_cnt", fetch_count, 32'd4);
    end
    drive(1'b1, 32'h2222_0004, 32'h0000_0014, 1'b1, 1'b1, 1'b0);
    chk("ws_rdy_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    chk_ifid("ws_done", 32'h2222_0004, 32'h0000_0014, 1'b1);
    chk("ws_done_addr", imem_addr, 32'h0000_0014);
    chk("ws_done_cnt", fetch_count, 32'd5);

    // load-use stall: PC and IF/ID frozen
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hBAD0_0001, 32'h0000_0018, 1'b0, 1'b0, 1'b0);
      tick();
      chk("hz_addr", imem_addr, 32'h0000_0014);
      chk_ifid("hz", 32'h2222_0004, 32'h0000_0014, 1'b1);
      chk("hz_cnt", fetch_count, 32'd5);
    end
    // PC held but IF/ID writable: bubble
    drive(1'b1, 32'hBAD0_0002, 32'h0000_0018, 1'b0, 1'b1, 1'b0);
    tick();
    chk("hzb_addr", imem_addr, 32'h0000_0014);
    chk_ifid("hzb", 32'h0000_0000, 32'h0000_0000, 1'b0);
    drive(1'b1, 32'h3333_0005, 32'h0000_0018, 1'b1, 1'b1, 1'b0);
    tick();
    chk_ifid("hz_go", 32'h3333_0005, 32'h0000_0018, 1'b1);
    chk("hz_go_cnt", fetch_count, 32'd6);

    // flush while response outstanding -> DRAIN, late response dropped
    drive(1'b0, 32'hBAD0_0003, 32'h0000_0040, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fl_addr", imem_addr, 32'h0000_0040);
    chk_ifid("fl", 32'h0000_0000, 32'h0000_0000, 1'b0);
    drive(1'b0, 32'hBAD0_0004, 32'h0000_0044, 1'b1, 1'b1, 1'b0);
    chk("dr_req", {31'd0, imem_req}, 32'd0);
    chk("dr_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    chk("dr_addr", imem_addr, 32'h0000_0040);
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0044, 1'b1, 1'b1, 1'b0);
    chk("dr2_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk_ifid("dr_drop", 32'h0000_0000, 32'h0000_0000, 1'b0);
    chk("dr_drop_cnt", fetch_count, 32'd6);
    drive(1'b1, 32'h4444_0040, 32'h0000_0044, 1'b1, 1'b1, 1'b0);
    chk("rf_req", {31'd0, imem_req}, 32'd1);
    chk("rf_addr", imem_addr, 32'h0000_0040);
    tick();
    chk_ifid("rf", 32'h4444_0040, 32'h0000_0044, 1'b1);
    chk("rf_cnt", fetch_count, 32'd7);

    // flush, then second flush while draining
    drive(1'b0, 32'hBAD0_0005, 32'h0000_0080, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fl1_addr", imem_addr, 32'h0000_0080);
    drive(1'b0, 32'hBAD0_0006, 32'h0000_0090, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fl2_addr", imem_addr, 32'h0000_0090);
    drive(1'b0, 32'hBAD0_0007, 32'h0000_0094, 1'b1, 1'b1, 1'b0);
    chk("fl2_req", {31'd0, imem_req}, 32'd0);
    chk("fl2_stall", {31'd0, fetch_stall}, 32'd1);

    // reset while in DRAIN
    reset = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0094, 1'b1, 1'b1, 1'b0);
    chk("rd_req", {31'd0, imem_req}, 32'd0);
    chk("rd_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    chk("rd_addr", imem_addr, 32'h0000_0000);
    chk("rd_cnt", fetch_count, 32'd0);
    chk_ifid("rd", 32'h0000_0000, 32'h0000_0000, 1'b0);
    reset = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    chk("rd_boot_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rd_boot_cnt", fetch_count, 32'd0);
    chk("rd_boot_valid", {31'd0, ifid_valid}, 32'd0);
    drive(1'b1, 32'h5555_0000, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    chk("rd_f_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk_ifid("rd_f", 32'h5555_0000, 32'h0000_0004, 1'b1);

    // PC wrap at the top of the address space
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4_out, 32'h0000_0000);
    drive(1'b1, 32'h6666_FFFC, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_ifid("wrap", 32'h6666_FFFC, 32'h0000_0000, 1'b1);
    chk("wrap_cnt", fetch_count, 32'd2);

    // counter wrap from a preset value
    force dut.r_fetch_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_fetch_count;
    drive(1'b1, 32'h7777_0000, 32'h0000_0004, 1'b1, 1'b1, 1'b0);
    tick();
    chk("cw_max", fetch_count, 32'hFFFF_FFFF);
    drive(1'b1, 32'h7777_0004, 32'h0000_0008, 1'b1, 1'b1, 1'b0);
    tick();
    chk("cw_zero", fetch_count, 32'h0000_0000);
    drive(1'b0, 32'h7777_0008, 32'h0000_000C, 1'b1, 1'b1, 1'b0);
    tick();
    chk("cw_hold", fetch_count, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
